// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared types for the FP add/sub arbiter: error codes, FSM state and IEEE-754 single field split.
package addpkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int SIG_W = 23;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_INVALID   = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } o_err_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_fields_t;

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// Request/response channels of the FP add/sub arbiter; slave is the arbiter side.
interface fp_addsub_arbiter_if;
    import addpkg::*;

    // valid/ready: a beat transfers on the rising edge where valid and ready are both high;
    // the requester holds its fields stable while valid is high and may drop valid before acceptance.
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_op;
    logic [1:0][FP_W-1:0] req_a;
    logic [1:0][FP_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [FP_W-1:0]      rsp_data;
    o_err_t               rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/fp_addsub_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way grant; a lone requester wins, a tie goes to the pointer rr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: two requesters share one external FP add/sub datapath, one op in flight.
// Define FP_ARB_STATS_EN to build the saturating per-requester op and error counters.
module fp_addsub_arbiter
    import addpkg::*;
#(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_addsub_arbiter_if.slave    bus,
    output logic                  opcode,
    output logic                  sign1,
    output logic                  sign2,
    output logic [EXP_W-1:0]      exp1,
    output logic [EXP_W-1:0]      exp2,
    output logic [SIG_W-1:0]      sig1,
    output logic [SIG_W-1:0]      sig2,
    input  logic [FP_W-1:0]       fp_out,
    input  o_err_t                err_o,
    output logic [1:0][CNT_W-1:0] ops_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output state_t                state_o
);

    localparam int CW = 4;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic            op_q, op_d;
    logic [FP_W-1:0] a_q, a_d;
    logic [FP_W-1:0] b_q, b_d;
    logic            id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FP_W-1:0] data_q, data_d;
    o_err_t          err_q, err_d;
    logic [1:0]      gnt;
    logic            win;
    logic            rsp_hs;
    fp_fields_t      fa, fb;

    rr_arb2 u_arb (
        .req (bus.req_valid),
        .rr  (rr_q),
        .gnt (gnt)
    );

    assign win    = gnt[1];
    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

    assign bus.req_ready = (state_q == ST_IDLE && !reset) ? gnt : 2'b00;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign state_o       = state_q;

    // Datapath fields come straight from the captured operands, so they hold through EXEC and RESP.
    assign fa     = a_q;
    assign fb     = b_q;
    assign opcode = op_q;
    assign sign1  = fa.sign;
    assign exp1   = fa.exp;
    assign sig1   = fa.sig;
    assign sign2  = fb.sign;
    assign exp2   = fb.exp;
    assign sig2   = fb.sig;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_d    = bus.req_op[win];
                    a_d     = bus.req_a[win];
                    b_d     = bus.req_b[win];
                    id_d    = win;
                    cnt_d   = CW'(LAT - 1);
                    rr_d    = !win;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    data_d  = fp_out;
                    err_d   = err_o;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef FP_ARB_STATS_EN
    logic [1:0][CNT_W-1:0] ops_q, ops_d;
    logic [CNT_W-1:0]      errc_q, errc_d;

    always_comb begin
        ops_d  = ops_q;
        errc_d = errc_q;
        if (rsp_hs) begin
            if (ops_q[id_q] != '1) begin
                ops_d[id_q] = ops_q[id_q] + CNT_W'(1);
            end
            if (err_q != ERR_NONE && errc_q != '1) begin
                errc_d = errc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q  <= '0;
            errc_q <= '0;
        end else begin
            ops_q  <= ops_d;
            errc_q <= errc_d;
        end
    end

    assign ops_cnt = ops_q;
    assign err_cnt = errc_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
    assign ops_cnt   = '0;
    assign err_cnt   = '0;
`endif

endmodule
